// File: rtl/dmem_pkg.sv
// Shared defaults, host FSM encoding and saturating-counter helpers for the
// data-memory responder.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck
  } host_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data bus plus 4-phase host request/acknowledge bus of the responder.
interface dmem_responder_if import dmem_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_dataout;
  logic              d_we;
  logic [DATA_W-1:0] d_datain;

  logic              h_req;
  logic              h_wr;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ack;
  logic [DATA_W-1:0] h_rdata;

  modport master (
    output d_addr, d_dataout, d_we, h_req, h_wr, h_addr, h_wdata,
    input  d_datain, h_ack, h_rdata
  );

  modport slave (
    input  d_addr, d_dataout, d_we, h_req, h_wr, h_addr, h_wdata,
    output d_datain, h_ack, h_rdata
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset.
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign cpu_rdata  = mem[cpu_raddr];
  assign host_rdata = mem[host_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data memory shared by the CPU (zero-latency port) and a host (4-phase
// handshake). CPU stores always win; a colliding host write is deferred.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  dmem_responder_if.slave     bus,
  output logic [15:0]         st_count,
  output logic [7:0]          host_stalls
);

  host_state_e state_q, state_d;

  logic              lat_wr_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [DATA_W-1:0] h_rdata_q;
  logic [15:0]       st_count_q;
  logic [7:0]        host_stalls_q;

  logic              latch_en, rdata_en, host_we, stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] host_rdata;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    rdata_en = 1'b0;
    host_we  = 1'b0;
    stall    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.h_req) begin
          latch_en = 1'b1;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (!lat_wr_q) begin
          rdata_en = 1'b1;
          state_d  = StAck;
        end else if (!bus.d_we) begin
          host_we = 1'b1;
          state_d = StAck;
        end else begin
          stall = 1'b1;
        end
      end
      StAck: begin
        if (!bus.h_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // host_we is only raised when d_we is low, so the ports never collide.
  assign mem_we    = bus.d_we | host_we;
  assign mem_waddr = bus.d_we ? bus.d_addr : lat_addr_q;
  assign mem_wdata = bus.d_we ? bus.d_dataout : lat_wdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      lat_wr_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      h_rdata_q     <= '0;
      st_count_q    <= '0;
      host_stalls_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        lat_wr_q    <= bus.h_wr;
        lat_addr_q  <= bus.h_addr;
        lat_wdata_q <= bus.h_wdata;
      end
      if (rdata_en)   h_rdata_q     <= host_rdata;
      if (bus.d_we)   st_count_q    <= sat_inc16(st_count_q);
      if (stall)      host_stalls_q <= sat_inc8(host_stalls_q);
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clock      (clock),
    .we         (mem_we),
    .waddr      (mem_waddr),
    .wdata      (mem_wdata),
    .cpu_raddr  (bus.d_addr),
    .cpu_rdata  (bus.d_datain),
    .host_raddr (lat_addr_q),
    .host_rdata (host_rdata)
  );

  assign bus.h_ack   = (state_q == StAck);
  assign bus.h_rdata = h_rdata_q;
  assign st_count    = st_count_q;
  assign host_stalls = host_stalls_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width (depth 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port d_addr  input  ADDR_W  CPU data address, driven from CPU EX-stage result register.
REQ-006 SHALL have port d_dataout  input  DATA_W  CPU store data.
REQ-007 SHALL have port d_we  input  1  CPU store strobe, one cycle per STORE.
REQ-008 SHALL have port d_datain  output  DATA_W  read data returned to CPU.
REQ-009 SHALL have port h_req  input  1  host request, 4-phase handshake.
REQ-010 SHALL have port h_wr  input  1  host request type, 1 = write, 0 = read.
REQ-011 SHALL have port h_addr  input  ADDR_W  host word address.
REQ-012 SHALL have port h_wdata  input  DATA_W  host write data.
REQ-013 SHALL have port h_ack  output  1  host acknowledge.
REQ-014 SHALL have port h_rdata  output  DATA_W  host read data, valid while h_ack=1.
REQ-015 SHALL have port st_count  output  16  number of CPU stores since reset, saturating.
REQ-016 SHALL have port host_stalls  output  8  cycles a host write was deferred by a CPU store, saturating.

Function
REQ-017 SHALL drive d_datain combinationally as mem[d_addr], so the CPU captures it on the edge after d_addr changes; no read latency.
REQ-018 SHALL write d_dataout to mem[d_addr] on a rising edge where d_we=1; a same-cycle read of that address returns the old content.
REQ-019 SHALL implement host FSM states IDLE, ACCESS, ACK.
REQ-020 SHALL, in IDLE with h_req=1, latch h_wr, h_addr and h_wdata and move to ACCESS; host inputs are ignored after the latch.
REQ-021 SHALL, in ACCESS with a latched read, register h_rdata = mem[latched addr] and move to ACK; latency from h_req rise to h_ack rise is 2 cycles.
REQ-022 SHALL, in ACCESS with a latched write and d_we=0, write mem[latched addr] = latched data and move to ACK.
REQ-023 SHALL, in ACCESS with a latched write and d_we=1, stay in ACCESS, skip the host write, and increment host_stalls; the CPU store always has priority.
REQ-024 SHALL hold h_ack=1 throughout ACK and move ACK->IDLE when h_req=0; h_ack is 0 in all other states.
REQ-025 SHALL keep h_rdata stable from ACK entry until the next read completes.
REQ-026 SHALL, when a deferred host write targets the address just stored by the CPU, leave the host value in memory (host write lands last).
REQ-027 SHALL increment st_count on every edge with d_we=1 and hold it at 16'hFFFF without wrapping; host_stalls holds at 8'hFF.
REQ-028 SHALL never write memory from both ports on the same edge.
REQ-029 SHALL treat d_we and the host port as fully independent of CPU run state; host access while the CPU executes is legal.

Reset
REQ-030 SHALL, while reset=0, force FSM=IDLE, h_ack=0, h_rdata=0, st_count=0, host_stalls=0 asynchronously.
REQ-031 SHALL NOT clear memory contents on reset; data survives a CPU reset.
REQ-032 SHALL abandon a host transaction interrupted by reset without writing; the host must re-request after reset release.

Structure
REQ-033 SHALL place the FSM state encoding and the ADDR_W/DATA_W defaults in shared package dmem_pkg.
REQ-034 SHALL instantiate one sub-module, dmem_array: 2**ADDR_W x DATA_W storage, one synchronous write port, two asynchronous read ports (CPU, host).

Verification
REQ-035 SHALL cover: CPU store d_addr=8'h10, d_dataout=16'hBEEF, d_we=1, then d_addr=8'h10 next cycle -> d_datain=16'hBEEF, st_count=1.
REQ-036 SHALL cover: host read of 8'h10 after REQ-035 -> h_ack rises 2 cycles after h_req, h_rdata=16'hBEEF, h_ack drops 1 cycle after h_req drops.
REQ-037 SHALL cover: host write 8'h20=16'h1234 with d_we=1 held 3 cycles to 8'h20=16'h5555 -> host_stalls=3, final mem[8'h20]=16'h1234.
REQ-038 SHALL cover: 65540 consecutive CPU stores -> st_count saturates at 16'hFFFF.
REQ-039 SHALL cover: reset=0 asserted while FSM in ACCESS with pending write 8'h30=16'hAAAA -> h_ack=0 immediately, mem[8'h30] unchanged, prior mem[8'h10]=16'hBEEF retained.
